// File: rtl/ecc_secded_pipe.sv
`timescale 1ns/1ps
// SECDED encode -> fault inject -> decode/correct pipeline with valid/ready flow control,
// saturating single/double error counters and a sticky first-error syndrome log.
module ecc_secded_pipe #(
  parameter int K     = 64,
  parameter int CNT_W = 16,
  parameter int PIPE  = 2,
  localparam int P    = $clog2(K + $clog2(K) + 1),
  localparam int N    = K + P + 1,
  localparam int IW   = $clog2(N + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [K-1:0]     d_i,
  input  logic [1:0]       inj_mode_i,
  input  logic [IW-1:0]    inj_bit1_i,
  input  logic [IW-1:0]    inj_bit2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [K-1:0]     q_o,
  output logic             sb_err_o,
  output logic             db_err_o,
  output logic [P-1:0]     syndrome_o,
  output logic [CNT_W-1:0] sb_cnt_o,
  output logic [CNT_W-1:0] db_cnt_o,
  output logic             ferr_valid_o,
  output logic [P:0]       ferr_syn_o
);

  // N may equal 2**P, so the range compare needs one extra bit.
  localparam logic [P:0] N_W = (P+1)'(N);

  function automatic logic is_data_pos(input int j);
    return (j & (j - 1)) != 0;
  endfunction

  function automatic logic [N-1:0] encode(input logic [K-1:0] d);
    logic [N-1:0] cw;
    int di;
    cw = '0;
    di = 0;
    for (int j = 1; j < N; j++) begin
      if (is_data_pos(j)) begin
        cw[j] = d[di];
        di++;
      end
    end
    for (int i = 0; i < P; i++) begin
      for (int j = 1; j < N; j++) begin
        if (is_data_pos(j) && (((j >> i) & 1) == 1)) cw[1 << i] = cw[1 << i] ^ cw[j];
      end
    end
    cw[0] = ^cw[N-1:1];
    return cw;
  endfunction

  function automatic logic [N-1:0] inj_mask(input logic [1:0] mode, input logic [IW-1:0] b1,
                                            input logic [IW-1:0] b2);
    logic [N-1:0] m;
    m = '0;
    for (int j = 0; j < N; j++) begin
      if ((mode == 2'b01 || mode == 2'b10) && int'(b1) == j) m[j] = ~m[j];
      if (mode == 2'b10 && int'(b2) == j) m[j] = ~m[j];
    end
    if (mode == 2'b11) m[0] = 1'b1;
    return m;
  endfunction

  function automatic logic [P-1:0] syndrome(input logic [N-1:0] cw);
    logic [P-1:0] s;
    s = '0;
    for (int j = 1; j < N; j++) begin
      if (cw[j]) s = s ^ P'(j);
    end
    return s;
  endfunction

  function automatic logic [N-1:0] flip_pos(input logic [N-1:0] cw, input logic [P-1:0] s);
    logic [N-1:0] r;
    r = cw;
    for (int j = 1; j < N; j++) begin
      if (P'(j) == s) r[j] = ~r[j];
    end
    return r;
  endfunction

  function automatic logic [K-1:0] extract(input logic [N-1:0] cw);
    logic [K-1:0] d;
    int di;
    d = '0;
    di = 0;
    for (int j = 1; j < N; j++) begin
      if (is_data_pos(j)) begin
        d[di] = cw[j];
        di++;
      end
    end
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic             last_ready;
  logic             in_ready;
  logic             ld_last;
  logic             xfer;
  logic [N-1:0]     cw_rx;
  logic [P-1:0]     syn_rx;
  logic             par_rx;
  logic [N-1:0]     src_cw;
  logic [P-1:0]     src_syn;
  logic             src_par;
  logic             s_in_range;
  logic             sb_nxt;
  logic             db_nxt;
  logic [K-1:0]     q_nxt;

  logic             vld_p2;
  logic [K-1:0]     q_p2;
  logic             sb_p2;
  logic             db_p2;
  logic [P-1:0]     syn_p2;
  logic             par_p2;
  logic [CNT_W-1:0] sb_cnt;
  logic [CNT_W-1:0] db_cnt;
  logic             ferr_vld;
  logic [P:0]       ferr_syn;

  always_comb begin
    cw_rx  = encode(d_i) ^ inj_mask(inj_mode_i, inj_bit1_i, inj_bit2_i);
    syn_rx = syndrome(cw_rx);
    par_rx = ^cw_rx;
  end

  assign last_ready = ~vld_p2 | out_ready_i;

  generate
    if (PIPE == 2) begin : g_two
      logic         vld_p1;
      logic [N-1:0] cw_p1;
      logic [P-1:0] syn_p1;
      logic         par_p1;

      // stage 1 boundary: received codeword plus its syndrome and overall parity
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          vld_p1 <= 1'b0;
        end else if (in_ready) begin
          vld_p1 <= in_valid_i;
        end
      end

      always_ff @(posedge clk_i) begin
        if (in_valid_i & in_ready) begin
          cw_p1  <= cw_rx;
          syn_p1 <= syn_rx;
          par_p1 <= par_rx;
        end
      end

      assign in_ready = ~vld_p1 | last_ready;
      assign ld_last  = vld_p1 & last_ready;
      assign src_cw   = cw_p1;
      assign src_syn  = syn_p1;
      assign src_par  = par_p1;
    end else begin : g_one
      assign in_ready = last_ready;
      assign ld_last  = in_valid_i & last_ready;
      assign src_cw   = cw_rx;
      assign src_syn  = syn_rx;
      assign src_par  = par_rx;
    end
  endgenerate

  always_comb begin
    s_in_range = ({1'b0, src_syn} < N_W);
    sb_nxt     = src_par & s_in_range;
    db_nxt     = (src_par & ~s_in_range) | (~src_par & (src_syn != '0));
    q_nxt      = extract(sb_nxt ? flip_pos(src_cw, src_syn) : src_cw);
  end

  // output stage boundary: corrected data and error classification
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p2 <= 1'b0;
      q_p2   <= '0;
      sb_p2  <= 1'b0;
      db_p2  <= 1'b0;
      syn_p2 <= '0;
      par_p2 <= 1'b0;
    end else if (ld_last) begin
      vld_p2 <= 1'b1;
      q_p2   <= q_nxt;
      sb_p2  <= sb_nxt;
      db_p2  <= db_nxt;
      syn_p2 <= src_syn;
      par_p2 <= src_par;
    end else if (out_ready_i) begin
      vld_p2 <= 1'b0;
    end
  end

  assign xfer = vld_p2 & out_ready_i;

  // Statistics only see beats the consumer actually takes; clear beats a same-cycle event.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_cnt   <= '0;
      db_cnt   <= '0;
      ferr_vld <= 1'b0;
      ferr_syn <= '0;
    end else if (clr_i) begin
      sb_cnt   <= '0;
      db_cnt   <= '0;
      ferr_vld <= 1'b0;
      ferr_syn <= '0;
    end else if (xfer) begin
      if (sb_p2) sb_cnt <= sat_inc(sb_cnt);
      if (db_p2) db_cnt <= sat_inc(db_cnt);
      if ((sb_p2 | db_p2) & ~ferr_vld) begin
        ferr_vld <= 1'b1;
        ferr_syn <= {par_p2, syn_p2};
      end
    end
  end

  assign in_ready_o   = in_ready;
  assign out_valid_o  = vld_p2;
  assign q_o          = q_p2;
  assign sb_err_o     = sb_p2;
  assign db_err_o     = db_p2;
  assign syndrome_o   = syn_p2;
  assign sb_cnt_o     = sb_cnt;
  assign db_cnt_o     = db_cnt;
  assign ferr_valid_o = ferr_vld;
  assign ferr_syn_o   = ferr_syn;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
`timescale 1ns/1ps
// Scoreboard bench for ecc_secded_pipe: error outcomes are predicted from the set of flipped
// codeword positions rather than by building codewords.
module tb_ecc_secded_pipe;

  localparam int NW = 72;

  typedef struct packed {
    logic [63:0] q;
    logic        sb;
    logic        db;
    logic [6:0]  syn;
    logic        par;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] d = '0;
  logic [1:0]  mode = '0;
  logic [6:0]  b1 = '0;
  logic [6:0]  b2 = '0;
  logic        rdy_hold = 1'b1;
  logic        bp_mode = 1'b0;
  logic        rnd_rdy = 1'b1;
  logic        out_ready;

  logic        in_ready, out_valid, sb, db, fv;
  logic [63:0] q;
  logic [6:0]  syn;
  logic [15:0] sb_cnt, db_cnt;
  logic [7:0]  fsyn;

  logic        s_in_ready, s_out_valid, s_sb, s_db, s_fv;
  logic [63:0] s_q;
  logic [6:0]  s_syn;
  logic [1:0]  s_sb_cnt, s_db_cnt;
  logic [7:0]  s_fsyn;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  logic [15:0] m_sb = '0;
  logic [15:0] m_db = '0;
  logic        m_fv = 1'b0;
  logic [7:0]  m_fsyn = '0;

  assign out_ready = bp_mode ? rnd_rdy : rdy_hold;

  always #5 clk = ~clk;

  ecc_secded_pipe #(.K(64), .CNT_W(16), .PIPE(2)) dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .d_i(d), .inj_mode_i(mode), .inj_bit1_i(b1), .inj_bit2_i(b2),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .q_o(q), .sb_err_o(sb), .db_err_o(db),
    .syndrome_o(syn), .sb_cnt_o(sb_cnt), .db_cnt_o(db_cnt), .ferr_valid_o(fv), .ferr_syn_o(fsyn)
  );

  ecc_secded_pipe #(.K(64), .CNT_W(2), .PIPE(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
    .d_i(d), .inj_mode_i(mode), .inj_bit1_i(b1), .inj_bit2_i(b2),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready), .q_o(s_q), .sb_err_o(s_sb),
    .db_err_o(s_db), .syndrome_o(s_syn), .sb_cnt_o(s_sb_cnt), .db_cnt_o(s_db_cnt),
    .ferr_valid_o(s_fv), .ferr_syn_o(s_fsyn)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Index of a data-carrying position: position minus the check positions at or below it, minus one.
  function automatic int data_idx(input int pos);
    int np;
    np = 0;
    for (int t = 1; t <= pos; t = t * 2) np++;
    return pos - np - 1;
  endfunction

  function automatic exp_t model(input logic [63:0] dd, input logic [1:0] md,
                                 input logic [6:0] p1, input logic [6:0] p2);
    logic [127:0] f;
    int pos[$];
    exp_t e;
    f = '0;
    if ((md == 2'b01 || md == 2'b10) && int'(p1) < NW) f[p1] = ~f[p1];
    if (md == 2'b10 && int'(p2) < NW) f[p2] = ~f[p2];
    if (md == 2'b11) f[0] = 1'b1;
    for (int j = 0; j < NW; j++) if (f[j]) pos.push_back(j);
    e = '{q: dd, sb: 1'b0, db: 1'b0, syn: 7'd0, par: 1'b0};
    if (pos.size() == 1) begin
      e.sb  = 1'b1;
      e.par = 1'b1;
      e.syn = 7'(pos[0]);
    end else if (pos.size() == 2) begin
      e.db  = 1'b1;
      e.syn = 7'(pos[0] ^ pos[1]);
      foreach (pos[k]) begin
        if (pos[k] > 0 && (pos[k] & (pos[k] - 1)) != 0) e.q[data_idx(pos[k])] = ~e.q[data_idx(pos[k])];
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  // Stimulus side of the scoreboard: record each accepted beat.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) sb_q.push_back(model(d, mode, b1, b2));
  end

  // Monitor: compare each delivered beat and the running statistics.
  always @(negedge clk) begin
    exp_t e;
    logic got;
    if (rst) begin
      sb_q.delete();
      m_sb = '0; m_db = '0; m_fv = 1'b0; m_fsyn = '0;
    end else begin
      got = 1'b0;
      chk("sb_cnt", sb_cnt, m_sb);
      chk("db_cnt", db_cnt, m_db);
      chk("ferr_valid", fv, m_fv);
      chk("ferr_syn", fsyn, m_fsyn);
      chk("sat_sb_cnt", s_sb_cnt, (m_sb > 3) ? 16'd3 : m_sb);
      chk("sat_db_cnt", s_db_cnt, (m_db > 3) ? 16'd3 : m_db);
      chk("sat_ferr_valid", s_fv, m_fv);
      chk("flags_exclusive", sb & db & out_valid, 1'b0);
      if (out_valid && out_ready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          got = 1'b1;
          chk("q", q, e.q);
          chk("sb_err", sb, e.sb);
          chk("db_err", db, e.db);
          chk("syndrome", syn, e.syn);
        end
      end
      if (clr) begin
        m_sb = '0; m_db = '0; m_fv = 1'b0; m_fsyn = '0;
      end else if (got) begin
        if (e.sb) m_sb = m_sb + 16'd1;
        if (e.db) m_db = m_db + 16'd1;
        if ((e.sb || e.db) && !m_fv) begin
          m_fv   = 1'b1;
          m_fsyn = {e.par, e.syn};
        end
      end
    end
  end

  task automatic send(input logic [63:0] dd, input logic [1:0] md, input logic [6:0] p1,
                      input logic [6:0] p2);
    logic acc;
    int g;
    g = 0;
    d = dd; mode = md; b1 = p1; b2 = p2; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      g++;
    end while (!acc && g < 200);
    if (!acc) chk("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_left", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    int g;
    int start;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_q", q, 64'd0);
    chk("rst_flags", {sb, db, syn}, 9'd0);
    chk("rst_cnts", {sb_cnt, db_cnt}, 32'd0);
    chk("rst_ferr", {fv, fsyn}, 9'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    send(64'd0, 2'b00, 7'd0, 7'd0);
    send(64'h0000_0200_0000_0000, 2'b00, 7'd0, 7'd0);
    drain();
    chk("t1_cnts", {sb_cnt, db_cnt}, 32'd0);

    send(64'h1, 2'b01, 7'd3, 7'd0);
    drain();
    chk("t2_sb_cnt", sb_cnt, 16'd1);
    chk("t2_ferr", {fv, fsyn}, {1'b1, 8'h83});

    pulse_clr();
    send({$urandom, $urandom}, 2'b10, 7'd3, 7'd5);
    drain();
    chk("t3_db_cnt", db_cnt, 16'd1);
    chk("t3_ferr", {fv, fsyn}, {1'b1, 8'h06});
    send({$urandom, $urandom}, 2'b10, 7'd5, 7'd5);
    drain();
    chk("t3_db_cnt_same", db_cnt, 16'd1);

    send({$urandom, $urandom}, 2'b11, 7'd0, 7'd0);
    send({$urandom, $urandom}, 2'b01, 7'd127, 7'd0);
    drain();
    chk("t4_sb_cnt", sb_cnt, 16'd1);

    start = n_out;
    rdy_hold = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send({32'hA5A5_0000 | 32'(i), $urandom}, 2'($urandom_range(0, 3)),
                                         7'($urandom_range(0, 75)), 7'($urandom_range(0, 75)));
      end
      begin
        repeat (6) @(negedge clk);
        chk("t5_in_ready_low", in_ready, 1'b0);
        chk("t5_buffered", sb_q.size(), 2);
        chk("t5_out_valid_held", out_valid, 1'b1);
        @(posedge clk);
        #1 rdy_hold = 1'b1;
      end
    join
    drain();
    chk("t5_beats_out", n_out - start, 8);

    pulse_clr();
    repeat (5) send({$urandom, $urandom}, 2'b01, 7'($urandom_range(1, 71)), 7'd0);
    drain();
    chk("t6_sat_sb", s_sb_cnt, 2'd3);
    chk("t6_main_sb", sb_cnt, 16'd5);
    rdy_hold = 1'b0;
    send({$urandom, $urandom}, 2'b01, 7'd9, 7'd0);
    g = 0;
    while (!out_valid && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("t6_beat_ready", out_valid, 1'b1);
    clr = 1'b1;
    rdy_hold = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("t6_clr_cnt", {sb_cnt, s_sb_cnt}, 18'd0);
    chk("t6_clr_ferr", {fv, s_fv}, 2'b00);

    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom}; mode = 2'($urandom_range(0, 3));
      b1 = 7'($urandom_range(0, 75)); b2 = 7'($urandom_range(0, 75)); in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_cnt", sb_cnt, 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    bp_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send({$urandom, $urandom}, 2'($urandom_range(0, 3)), 7'($urandom_range(0, 80)),
           7'($urandom_range(0, 80)));
    end
    drain();
    bp_mode = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 2000000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
